clock_set_ctrl: RTL and testbench

- Button-driven setting controller for the alarm clock core.
- Turns mode, increment and cancel buttons into the core's H_in1/H_in0/M_in1/M_in0 values and single-cycle LD_time / LD_alarm load pulses.
- Holds a shadow copy of the programmed alarm time.
- Sits between the front-panel button synchronisers and the clock core; it runs on the same clk.

---
 rtl/clock_set_pkg.sv | 19 +
 rtl/clock_set_ctrl_btn_edge_rpt.sv | 27 ++
 rtl/clock_set_ctrl.sv | 75 +++++++
 tb/tb_clock_set_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/clock_set_pkg.sv
// clock_set_pkg: shared state encoding, field codes, BCD limits and digit-increment helpers for clock_set_ctrl
package clock_set_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, T_HR, T_MIN, A_HR, A_MIN} state_t;
  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HR = 2'd1;
  localparam logic [1:0] FIELD_MIN = 2'd2;
  localparam logic [1:0] HR_MAX1 = 2'd2;
  localparam logic [3:0] HR_MAX0 = 4'd3;
  localparam logic [3:0] MIN_MAX1 = 4'd5;
  localparam logic [3:0] DIG_MAX = 4'd9;
  function automatic logic [5:0] hr_inc(input logic [1:0] h1, input logic [3:0] h0);
    return (h1 > HR_MAX1 || (h1 == HR_MAX1 && h0 >= HR_MAX0) || h0 > DIG_MAX) ? 6'd0 :
           h0 == DIG_MAX ? {h1 + 2'd1, 4'd0} : {h1, h0 + 4'd1};
  endfunction
  function automatic logic [7:0] min_inc(input logic [3:0] m1, input logic [3:0] m0);
    return (m1 > MIN_MAX1 || m0 > DIG_MAX) ? 8'd0 :
           m0 == DIG_MAX ? {m1 == MIN_MAX1 ? 4'd0 : m1 + 4'd1, 4'd0} : {m1, m0 + 4'd1};
  endfunction
endpackage

// File: rtl/clock_set_ctrl_btn_edge_rpt.sv
// btn_edge_rpt: rising-edge pulse for a synchronised button, optionally repeating every REPEAT_DLY cycles while held
module btn_edge_rpt #(
  parameter bit RPT_EN = 1'b0,
  parameter int REPEAT_DLY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  localparam logic [7:0] LAST = 8'(REPEAT_DLY - 1);
  logic prev;
  logic rise;
  logic [7:0] cnt;
  always_comb begin
    rise = btn & ~prev;
    pulse = rise | (RPT_EN & btn & prev & (cnt == LAST));
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      prev <= 1'b0;
      cnt <= '0;
    end else begin
      prev <= btn;
      cnt <= (!btn || rise || cnt == LAST) ? 8'd0 : cnt + 8'd1;
    end
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven time/alarm setting FSM for the clock core (auto-repeat increment under CLOCK_SET_AUTO_REPEAT_EN)
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int TIMEOUT_CYC = 30,
  parameter int REPEAT_DLY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_cancel,
  input  logic [1:0] cur_H1,
  input  logic [3:0] cur_H0,
  input  logic [3:0] cur_M1,
  input  logic [3:0] cur_M0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic [1:0] edit_field,
  output logic       set_alarm,
  output logic       busy
);
`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam bit AUTO_RPT = 1'b1;
`else
  localparam bit AUTO_RPT = 1'b0;
`endif
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  state_t state, state_n;
  logic mode_e, inc_e, cancel_e;
  logic timeout, abort, adv, bump;
  logic [7:0] to_cnt;
  logic [1:0] sh_h1;
  logic [3:0] sh_h0, sh_m1, sh_m0;
  btn_edge_rpt #(.RPT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY)) u_mode (.clk(clk), .reset(reset), .btn(btn_mode), .pulse(mode_e));
  btn_edge_rpt #(.RPT_EN(AUTO_RPT), .REPEAT_DLY(REPEAT_DLY)) u_inc (.clk(clk), .reset(reset), .btn(btn_inc), .pulse(inc_e));
  btn_edge_rpt #(.RPT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY)) u_cancel (.clk(clk), .reset(reset), .btn(btn_cancel), .pulse(cancel_e));
  // timeout acts as a cancel; cancel beats mode, mode beats increment
  always_comb begin
    timeout = state != IDLE && to_cnt == TO_LAST;
    abort = cancel_e || timeout;
    adv = mode_e && !abort;
    bump = state != IDLE && inc_e && !mode_e && !abort;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = abort ? IDLE : !adv ? state : state == A_MIN ? IDLE : state_t'(state + 3'd1);
  always_comb begin
    busy = state != IDLE;
    set_alarm = state == A_HR || state == A_MIN;
    edit_field = (state == T_HR || state == A_HR) ? FIELD_HR :
                 (state == T_MIN || state == A_MIN) ? FIELD_MIN : FIELD_NONE;
    LD_time = state == T_MIN && adv;
    LD_alarm = state == A_MIN && adv;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {H_in1, H_in0, M_in1, M_in0} <= '0;
      {sh_h1, sh_h0, sh_m1, sh_m0} <= '0;
      to_cnt <= '0;
    end else begin
      to_cnt <= (state == IDLE || state_n != state || mode_e || inc_e || cancel_e) ? 8'd0 : to_cnt + 8'd1;
      if (LD_alarm) {sh_h1, sh_h0, sh_m1, sh_m0} <= {H_in1, H_in0, M_in1, M_in0};
      if (state == IDLE && adv) {H_in1, H_in0, M_in1, M_in0} <= {cur_H1, cur_H0, cur_M1, cur_M0};
      else if (LD_time) {H_in1, H_in0, M_in1, M_in0} <= {sh_h1, sh_h0, sh_m1, sh_m0};
      else if (bump && edit_field == FIELD_HR) {H_in1, H_in0} <= hr_inc(H_in1, H_in0);
      else if (bump) {M_in1, M_in0} <= min_inc(M_in1, M_in0);
    end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed scoreboard bench for clock_set_ctrl
module tb_clock_set_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_mode = 1'b0, btn_inc = 1'b0, btn_cancel = 1'b0;
  logic [1:0] cur_H1 = '0;
  logic [3:0] cur_H0 = '0, cur_M1 = '0, cur_M0 = '0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic LD_time, LD_alarm, set_alarm, busy;
  logic [1:0] edit_field;
  typedef struct {
    string tag;
    logic [19:0] v;
  } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam int RPT_EXP = 4;
`else
  localparam int RPT_EXP = 1;
`endif
  always #5 clk = ~clk;
  clock_set_ctrl #(.TIMEOUT_CYC(30), .REPEAT_DLY(4)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_cancel(btn_cancel),
    .cur_H1(cur_H1), .cur_H0(cur_H0), .cur_M1(cur_M1), .cur_M0(cur_M0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .edit_field(edit_field), .set_alarm(set_alarm), .busy(busy)
  );
  function automatic logic [19:0] ev(input int hh, input int mm, input int st, input logic lt = 1'b0, input logic la = 1'b0);
    logic [1:0] f;
    f = st == 0 ? 2'd0 : (st == 1 || st == 3) ? 2'd1 : 2'd2;
    return {2'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), lt, la, f, st >= 3, st != 0};
  endfunction
  function automatic logic [19:0] act();
    return {H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, edit_field, set_alarm, busy};
  endfunction
  task automatic sample(input string tag, input logic [19:0] v);
    exp_t e;
    sb.push_back('{tag, v});
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    assert (act() === e.v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", e.tag, act(), e.v);
    end
  endtask
  task automatic chk(input string tag, input logic [19:0] v);
    sample(tag, v);
    @(posedge clk);
    #1;
  endtask
  task automatic tap(input string tag, input logic m, input logic i, input logic c, input logic [19:0] v);
    btn_mode = m;
    btn_inc = i;
    btn_cancel = c;
    sample(tag, v);
    @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    btn_cancel = 1'b0;
  endtask
  task automatic set_cur(input int hh, input int mm);
    cur_H1 = 2'(hh / 10);
    cur_H0 = 4'(hh % 10);
    cur_M1 = 4'(mm / 10);
    cur_M0 = 4'(mm % 10);
  endtask
  initial begin
    set_cur(10, 19);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", ev(0, 0, 0));
    reset = 1'b1;
    chk("post_reset", ev(0, 0, 0));
    tap("a_mode_idle", 1, 0, 0, ev(0, 0, 0));
    chk("a_capture", ev(10, 19, 1));
    tap("a_inc1", 0, 1, 0, ev(10, 19, 1));
    chk("a_h11", ev(11, 19, 1));
    tap("a_inc2", 0, 1, 0, ev(11, 19, 1));
    chk("a_h12", ev(12, 19, 1));
    tap("a_mode_thr", 1, 0, 0, ev(12, 19, 1));
    chk("a_tmin", ev(12, 19, 2));
    tap("a_inc3", 0, 1, 0, ev(12, 19, 2));
    chk("a_m20", ev(12, 20, 2));
    tap("a_ld_time", 1, 0, 0, ev(12, 20, 2, 1));
    chk("a_ahr_shadow0", ev(0, 0, 3));
    for (int i = 0; i < 10; i++) begin
      tap("b_hinc_during", 0, 1, 0, ev(i, 0, 3));
      chk("b_hinc", ev(i + 1, 0, 3));
    end
    tap("b_mode_ahr", 1, 0, 0, ev(10, 0, 3));
    chk("b_amin", ev(10, 0, 4));
    for (int i = 0; i < 20; i++) begin
      tap("b_minc_during", 0, 1, 0, ev(10, i, 4));
      chk("b_minc", ev(10, i + 1, 4));
    end
    tap("b_ld_alarm", 1, 0, 0, ev(10, 20, 4, 0, 1));
    chk("b_idle_hold", ev(10, 20, 0));
    tap("c_mode1", 1, 0, 0, ev(10, 20, 0));
    chk("c_thr", ev(10, 19, 1));
    tap("c_mode2", 1, 0, 0, ev(10, 19, 1));
    chk("c_tmin", ev(10, 19, 2));
    tap("c_ld_time", 1, 0, 0, ev(10, 19, 2, 1));
    chk("c_shadow", ev(10, 20, 3));
    for (int i = 0; i < 29; i++) chk("to_waiting", ev(10, 20, 3));
    chk("to_idle", ev(10, 20, 0));
    tap("d_mode", 1, 0, 0, ev(10, 20, 0));
    chk("d_thr", ev(10, 19, 1));
    tap("d_mode_cancel", 1, 0, 1, ev(10, 19, 1));
    chk("d_cancel_wins", ev(10, 19, 0));
    tap("d_m1", 1, 0, 0, ev(10, 19, 0));
    chk("d_thr2", ev(10, 19, 1));
    tap("d_m2", 1, 0, 0, ev(10, 19, 1));
    chk("d_tmin2", ev(10, 19, 2));
    tap("d_ld_time", 1, 0, 0, ev(10, 19, 2, 1));
    chk("d_shadow_kept", ev(10, 20, 3));
    tap("d_cancel", 0, 0, 1, ev(10, 20, 3));
    chk("d_idle", ev(10, 20, 0));
    set_cur(23, 59);
    tap("e_m1", 1, 0, 0, ev(10, 20, 0));
    chk("e_thr", ev(23, 59, 1));
    tap("e_m2", 1, 0, 0, ev(23, 59, 1));
    chk("e_tmin", ev(23, 59, 2));
    tap("e_inc59", 0, 1, 0, ev(23, 59, 2));
    chk("e_m59_wrap", ev(23, 0, 2));
    tap("e_cancel1", 0, 0, 1, ev(23, 0, 2));
    chk("e_idle1", ev(23, 0, 0));
    tap("e_m3", 1, 0, 0, ev(23, 0, 0));
    chk("e_thr2", ev(23, 59, 1));
    tap("e_inc23", 0, 1, 0, ev(23, 59, 1));
    chk("e_h23_wrap", ev(0, 59, 1));
    tap("e_cancel2", 0, 0, 1, ev(0, 59, 1));
    chk("e_idle2", ev(0, 59, 0));
    set_cur(19, 9);
    tap("e_m4", 1, 0, 0, ev(0, 59, 0));
    chk("e_thr3", ev(19, 9, 1));
    tap("e_inc19", 0, 1, 0, ev(19, 9, 1));
    chk("e_h19_carry", ev(20, 9, 1));
    tap("e_m5", 1, 0, 0, ev(20, 9, 1));
    chk("e_tmin3", ev(20, 9, 2));
    tap("e_inc09", 0, 1, 0, ev(20, 9, 2));
    chk("e_m09_carry", ev(20, 10, 2));
    tap("e_cancel3", 0, 0, 1, ev(20, 10, 2));
    chk("e_idle3", ev(20, 10, 0));
    set_cur(27, 70);
    tap("e_m6", 1, 0, 0, ev(20, 10, 0));
    chk("e_thr_bad", ev(27, 70, 1));
    tap("e_inc_hbad", 0, 1, 0, ev(27, 70, 1));
    chk("e_hbad_wrap", ev(0, 70, 1));
    tap("e_m7", 1, 0, 0, ev(0, 70, 1));
    chk("e_tmin_bad", ev(0, 70, 2));
    tap("e_inc_mbad", 0, 1, 0, ev(0, 70, 2));
    chk("e_mbad_wrap", ev(0, 0, 2));
    tap("e_cancel4", 0, 0, 1, ev(0, 0, 2));
    chk("e_idle4", ev(0, 0, 0));
    set_cur(7, 45);
    tap("f_m1", 1, 0, 0, ev(0, 0, 0));
    chk("f_thr", ev(7, 45, 1));
    tap("f_m2", 1, 0, 0, ev(7, 45, 1));
    chk("f_tmin", ev(7, 45, 2));
    reset = 1'b0;
    btn_mode = 1'b1;
    chk("f_rst_mid_edit", ev(0, 0, 0));
    btn_mode = 1'b0;
    reset = 1'b1;
    chk("f_after_rst", ev(0, 0, 0));
    set_cur(5, 0);
    tap("g_m1", 1, 0, 0, ev(0, 0, 0));
    chk("g_thr", ev(5, 0, 1));
    tap("g_m2", 1, 0, 0, ev(5, 0, 1));
    chk("g_tmin", ev(5, 0, 2));
    btn_inc = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    btn_inc = 1'b0;
    chk("g_hold_inc", ev(5, RPT_EXP, 2));
    tap("g_cancel", 0, 0, 1, ev(5, RPT_EXP, 2));
    chk("g_idle", ev(5, RPT_EXP, 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
